// File: rtl/light_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | light_req_ctrl: debounces the left/right/hazard switches and issues one   |
// | spaced, prioritised request pulse per press. Option: LIGHT_REQ_SYNC_EN.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module light_req_ctrl #(
   parameter int DB_CYCLES = 4,
   parameter int LOCKOUT   = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_left,
   input  logic sw_right,
   input  logic sw_haz,
   output logic a,
   output logic b,
   output logic c
);

   localparam logic [7:0] c_DB_LAST = 8'(DB_CYCLES - 1);
   localparam logic [7:0] c_LOCKOUT = 8'(LOCKOUT);

   // Channel index: 0 = left, 1 = right, 2 = hazard (highest priority).
   logic [2:0] w_raw;
   logic [2:0] w_s;
   logic [2:0] w_rise;
   logic [2:0] w_grant;
   logic [2:0] r_p;
   logic [2:0] r_out;
   logic [7:0] r_lk;

   assign w_raw = {sw_haz, sw_right, sw_left};

`ifdef LIGHT_REQ_SYNC_EN
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;
`else
   assign w_s = w_raw;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic       r_db;
         logic [7:0] r_cnt;
         logic       w_flip;

         assign w_flip     = (w_s[gi] != r_db) && (r_cnt == c_DB_LAST);
         assign w_rise[gi] = w_flip && w_s[gi];

         always_ff @(posedge clk) begin
            if (reset) begin
               r_db  <= 1'b0;
               r_cnt <= 8'd0;
            end else if (w_s[gi] == r_db) begin
               r_cnt <= 8'd0;
            end else if (w_flip) begin
               r_db  <= w_s[gi];
               r_cnt <= 8'd0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   endgenerate

   always_comb begin
      w_grant = 3'b000;
      if (r_lk == 8'd0) begin
         if (r_p[2]) begin
            w_grant = 3'b100;
         end else if (r_p[1]) begin
            w_grant = 3'b010;
         end else if (r_p[0]) begin
            w_grant = 3'b001;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_p   <= 3'b000;
         r_lk  <= 8'd0;
         r_out <= 3'b000;
      end else begin
         // A fresh rise on the same edge as its issue keeps the request pending.
         r_p   <= (r_p & ~w_grant) | w_rise;
         r_out <= w_grant;
         if (w_grant != 3'b000) begin
            r_lk <= c_LOCKOUT;
         end else if (r_lk != 8'd0) begin
            r_lk <= r_lk - 8'd1;
         end
      end
   end

   assign a = r_out[0];
   assign b = r_out[1];
   assign c = r_out[2];

endmodule
`default_nettype wire

// File: tb/tb_light_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_light_req_ctrl: directed and random checks of light_req_ctrl against   |
// | a sample-history reference model. Honours LIGHT_REQ_SYNC_EN.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_light_req_ctrl;

   localparam int DB = 4;
   localparam int LK = 3;
`ifdef LIGHT_REQ_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic sw_left;
   logic sw_right;
   logic sw_haz;
   logic a;
   logic b;
   logic c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   light_req_ctrl #(
      .DB_CYCLES(DB),
      .LOCKOUT  (LK)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sw_left (sw_left),
      .sw_right(sw_right),
      .sw_haz  (sw_haz),
      .a       (a),
      .b       (b),
      .c       (c)
   );

   // Reference model: a level is accepted once the last DB samples all agree
   // with each other and differ from it; issues are spaced by edge arithmetic.
   bit hist [3][$];
   bit dly  [3][$];
   bit m_db [3];
   bit m_p  [3];
   int edge_no    = 0;
   int last_issue = -1000;
   logic exp_a = 1'b0;
   logic exp_b = 1'b0;
   logic exp_c = 1'b0;

   task automatic model_edge();
      bit raw  [3];
      bit rise [3];
      bit s;
      bit same;
      int g;
      raw[0] = sw_left;
      raw[1] = sw_right;
      raw[2] = sw_haz;
      edge_no++;
      exp_a = 1'b0;
      exp_b = 1'b0;
      exp_c = 1'b0;
      if (reset) begin
         for (int ch = 0; ch < 3; ch++) begin
            hist[ch].delete();
            dly[ch].delete();
            for (int k = 0; k < SYNC; k++) dly[ch].push_back(1'b0);
            m_db[ch] = 1'b0;
            m_p[ch]  = 1'b0;
         end
         last_issue = -1000;
         return;
      end
      for (int ch = 0; ch < 3; ch++) begin
`ifdef LIGHT_REQ_SYNC_EN
         dly[ch].push_back(raw[ch]);
         s = dly[ch].pop_front();
`else
         s = raw[ch];
`endif
         hist[ch].push_back(s);
         if (hist[ch].size() > DB) void'(hist[ch].pop_front());
         same = (hist[ch].size() == DB);
         for (int k = 0; k < hist[ch].size(); k++)
            if (hist[ch][k] != s) same = 1'b0;
         rise[ch] = 1'b0;
         if (same && (s != m_db[ch])) begin
            m_db[ch] = s;
            rise[ch] = s;
         end
      end
      g = -1;
      if (edge_no - last_issue > LK) begin
         for (int ch = 2; ch >= 0; ch--)
            if (g < 0 && m_p[ch]) g = ch;
      end
      if (g >= 0) begin
         m_p[g]     = 1'b0;
         last_issue = edge_no;
      end
      exp_a = (g == 0);
      exp_b = (g == 1);
      exp_c = (g == 2);
      for (int ch = 0; ch < 3; ch++)
         if (rise[ch]) m_p[ch] = 1'b1;
   endtask

   task automatic check(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_no, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("model_a", a, exp_a);
      check("model_b", b, exp_b);
      check("model_c", c, exp_c);
   endtask

   task automatic idle(input int n);
      sw_left  = 1'b0;
      sw_right = 1'b0;
      sw_haz   = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int hold [3];
      bit lvl  [3];

      reset    = 1'b1;
      sw_left  = 1'b0;
      sw_right = 1'b0;
      sw_haz   = 1'b0;
      step();
      step();
      check("reset_a", a, 1'b0);
      check("reset_b", b, 1'b0);
      check("reset_c", c, 1'b0);
      reset = 1'b0;

      // Held hazard switch: exactly one c pulse.
      sw_haz = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         check("haz_single_c", c, 1'(i == 5 + SYNC));
      end
      idle(12);

      // Short left glitch is filtered.
      for (int i = 1; i <= 14; i++) begin
         sw_left = (i <= 3);
         step();
         check("glitch_no_a", a, 1'b0);
      end
      idle(4);

      // Simultaneous presses drain in priority order.
      for (int i = 1; i <= 16; i++) begin
         sw_left  = 1'b1;
         sw_right = 1'b1;
         sw_haz   = 1'b1;
         step();
         check("prio_c", c, 1'(i == 5 + SYNC));
         check("prio_b", b, 1'(i == 9 + SYNC));
         check("prio_a", a, 1'(i == 13 + SYNC));
      end
      idle(12);

      // Right re-pressed during the lockout that follows its own pulse.
      for (int i = 1; i <= 18; i++) begin
         sw_haz   = 1'b1;
         sw_right = (i <= 4) || (i >= 9);
         step();
         check("repress_c", c, 1'(i == 5 + SYNC));
         check("repress_b", b, 1'(i == 9 + SYNC || i == 13 + SYNC));
      end
      idle(12);

      // Reset right after a c pulse while left is pending; hazard held through reset.
      for (int i = 1; i <= 5 + SYNC; i++) begin
         sw_haz  = 1'b1;
         sw_left = (i <= 4);
         step();
         check("pre_reset_a", a, 1'b0);
      end
      check("pre_reset_c", c, 1'b1);
      reset = 1'b1;
      step();
      check("on_reset_a", a, 1'b0);
      check("on_reset_c", c, 1'b0);
      reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         check("post_reset_a", a, 1'b0);
         check("post_reset_held_c", c, 1'(i == 5 + SYNC));
      end
      for (int i = 1; i <= 12; i++) begin
         sw_haz  = 1'b0;
         sw_left = 1'b1;
         step();
         check("repress_left_a", a, 1'(i == 5 + SYNC));
      end
      idle(12);

      // Random bouncy switches with occasional reset.
      for (int ch = 0; ch < 3; ch++) begin
         hold[ch] = 0;
         lvl[ch]  = 1'b0;
      end
      for (int i = 0; i < 600; i++) begin
         for (int ch = 0; ch < 3; ch++) begin
            if (hold[ch] == 0) begin
               lvl[ch]  = ~lvl[ch];
               hold[ch] = $urandom_range(1, 2 * DB + 3);
            end
            hold[ch]--;
         end
         sw_left  = lvl[0];
         sw_right = lvl[1];
         sw_haz   = lvl[2];
         reset    = ($urandom_range(0, 149) == 0);
         step();
      end
      reset = 1'b0;
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
